// File: rtl/parking_pkg.sv
// Types and widths shared by the entry front-end and parking_system.
package parking_pkg;

  localparam int PASS_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2,
    READY   = 2'd3
  } state_t;

endpackage

// File: rtl/parking_debounce.sv
// Two-flop synchronizer followed by a stability counter; the output moves only
// after the synchronized input has disagreed with it for DEBOUNCE_CYCLES samples.
module parking_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sensor_raw,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
    end else begin
      sync_1 <= sensor_raw;
      sync_2 <= sync_1;
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync_2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_entry_frontend.sv
// Debounced loop sensors plus the two-digit keypad collector that feeds parking_system.
//   state   | meaning
//   IDLE    | no vehicle session; keys ignored
//   WAIT_D1 | entry seen, waiting for first digit
//   WAIT_D2 | first digit held, waiting for second
//   READY   | both digits held until exit edge or clear
module parking_entry_frontend
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              entry_sensor_raw,
  input  logic              exit_sensor_raw,
  input  logic              key_valid,
  input  logic [PASS_W-1:0] key_code,
  input  logic              key_clear,
  output logic              entry_detect,
  output logic              exit_detect,
  output logic [PASS_W-1:0] pass_1,
  output logic [PASS_W-1:0] pass_2,
  output logic              pass_ready,
  output logic              timeout_flag
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic               entry_prev;
  logic               exit_prev;
  logic               entry_rise;
  logic               exit_rise;

  parking_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry_db (
    .clk        (clk),
    .rst_n      (rst_n),
    .sensor_raw (entry_sensor_raw),
    .level      (entry_detect)
  );

  parking_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_db (
    .clk        (clk),
    .rst_n      (rst_n),
    .sensor_raw (exit_sensor_raw),
    .level      (exit_detect)
  );

  assign entry_rise = entry_detect & ~entry_prev;
  assign exit_rise  = exit_detect  & ~exit_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      pass_1       <= '0;
      pass_2       <= '0;
      pass_ready   <= 1'b0;
      timeout_flag <= 1'b0;
      entry_prev   <= 1'b0;
      exit_prev    <= 1'b0;
    end else begin
      entry_prev   <= entry_detect;
      exit_prev    <= exit_detect;
      timeout_flag <= 1'b0;
      // pass_ready lags state by one cycle by design
      pass_ready   <= (state == READY);

      if (state != IDLE && key_clear) begin
        state  <= WAIT_D1;
        pass_1 <= '0;
        pass_2 <= '0;
        timer  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (entry_rise) begin
              state <= WAIT_D1;
              timer <= '0;
            end
          end
          WAIT_D1, WAIT_D2: begin
            if (key_valid) begin
              timer <= '0;
              if (state == WAIT_D1) begin
                pass_1 <= key_code;
                state  <= WAIT_D2;
              end else begin
                pass_2 <= key_code;
                state  <= READY;
              end
            end else if (timer == TIMER_MAX) begin
              state        <= IDLE;
              pass_1       <= '0;
              pass_2       <= '0;
              timer        <= '0;
              timeout_flag <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          READY: begin
            if (exit_rise) begin
              state  <= IDLE;
              pass_1 <= '0;
              pass_2 <= '0;
              timer  <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parking_entry_frontend.sv
// Directed bench for parking_entry_frontend with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16.
module tb_parking_entry_frontend;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       entry_sensor_raw = 1'b0;
  logic       exit_sensor_raw = 1'b0;
  logic       key_valid = 1'b0;
  logic [1:0] key_code = 2'd0;
  logic       key_clear = 1'b0;
  logic       entry_detect;
  logic       exit_detect;
  logic [1:0] pass_1;
  logic [1:0] pass_2;
  logic       pass_ready;
  logic       timeout_flag;

  int checks = 0;
  int failures = 0;

  parking_entry_frontend #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .entry_sensor_raw (entry_sensor_raw),
    .exit_sensor_raw  (exit_sensor_raw),
    .key_valid        (key_valid),
    .key_code         (key_code),
    .key_clear        (key_clear),
    .entry_detect     (entry_detect),
    .exit_detect      (exit_detect),
    .pass_1           (pass_1),
    .pass_2           (pass_2),
    .pass_ready       (pass_ready),
    .timeout_flag     (timeout_flag)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] code);
    key_valid = 1'b1;
    key_code  = code;
    tick();
    key_valid = 1'b0;
    key_code  = 2'd0;
  endtask

  task automatic test_reset();
    logic [8:0] outs;
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      entry_sensor_raw = ~entry_sensor_raw;
      exit_sensor_raw  = i[0];
      tick();
    end
    outs = {entry_detect, exit_detect, pass_1, pass_2, pass_ready, timeout_flag};
    checks++;
    if (outs !== 9'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", outs, 9'd0);
    end
    entry_sensor_raw = 1'b0;
    exit_sensor_raw  = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({entry_detect, exit_detect, pass_ready} !== 3'b000) begin
        failures++;
        $display("FAIL post_reset_quiet cycle=%0d got=%b exp=000", i,
                 {entry_detect, exit_detect, pass_ready});
      end
    end
  endtask

  task automatic test_debounce();
    entry_sensor_raw = 1'b1;
    repeat (3) tick();
    entry_sensor_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (entry_detect !== 1'b0) begin
        failures++;
        $display("FAIL glitch_filtered cycle=%0d got=%b exp=0", i, entry_detect);
      end
    end
    entry_sensor_raw = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (entry_detect !== (k == 6)) begin
        failures++;
        $display("FAIL debounce_latency cycle=%0d got=%b exp=%b", k, entry_detect, (k == 6));
      end
    end
    tick();
  endtask

  task automatic test_password();
    int bad;
    press(2'd1);
    checks++;
    if (pass_1 !== 2'd1) begin
      failures++;
      $display("FAIL capture_d1 got=%0d exp=1", pass_1);
    end
    press(2'd2);
    checks++;
    if (pass_2 !== 2'd2 || pass_ready !== 1'b0) begin
      failures++;
      $display("FAIL capture_d2 got=%0d/%b exp=2/0", pass_2, pass_ready);
    end
    tick();
    checks++;
    if (pass_ready !== 1'b1) begin
      failures++;
      $display("FAIL pass_ready_rise got=%b exp=1", pass_ready);
    end
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (pass_1 !== 2'd1 || pass_2 !== 2'd2 || pass_ready !== 1'b1 || timeout_flag !== 1'b0)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL ready_hold bad_cycles=%0d exp=0", bad);
    end
    press(2'd3);
    tick();
    checks++;
    if ({pass_1, pass_2, pass_ready} !== {2'd1, 2'd2, 1'b1}) begin
      failures++;
      $display("FAIL third_key_ignored got=%0d/%0d/%b exp=1/2/1", pass_1, pass_2, pass_ready);
    end
    exit_sensor_raw = 1'b1;
    repeat (6) tick();
    checks++;
    if (exit_detect !== 1'b1) begin
      failures++;
      $display("FAIL exit_debounce got=%b exp=1", exit_detect);
    end
    tick();
    checks++;
    if (pass_1 !== 2'd0 || pass_2 !== 2'd0) begin
      failures++;
      $display("FAIL exit_clears_pass got=%0d/%0d exp=0/0", pass_1, pass_2);
    end
    tick();
    checks++;
    if (pass_ready !== 1'b0) begin
      failures++;
      $display("FAIL exit_drops_ready got=%b exp=0", pass_ready);
    end
    exit_sensor_raw  = 1'b0;
    entry_sensor_raw = 1'b0;
    repeat (10) tick();
  endtask

  // From IDLE with entry low and settled: state is WAIT_D1 with timer 0 on return.
  task automatic enter_session();
    entry_sensor_raw = 1'b1;
    repeat (7) tick();
  endtask

  task automatic test_timeout();
    enter_session();
    press(2'd3);
    for (int k = 1; k <= 17; k++) begin
      tick();
      checks++;
      if (timeout_flag !== (k == 16)) begin
        failures++;
        $display("FAIL timeout_pulse cycle=%0d got=%b exp=%b", k, timeout_flag, (k == 16));
      end
      if (k == 16) begin
        checks++;
        if (pass_1 !== 2'd0) begin
          failures++;
          $display("FAIL timeout_clears_pass got=%0d exp=0", pass_1);
        end
      end
    end
    entry_sensor_raw = 1'b0;
    repeat (10) tick();
    press(2'd1);
    checks++;
    if (pass_1 !== 2'd0) begin
      failures++;
      $display("FAIL idle_after_timeout got=%0d exp=0", pass_1);
    end
  endtask

  task automatic test_clear_and_race();
    enter_session();
    press(2'd2);
    key_clear = 1'b1;
    press(2'd1);
    key_clear = 1'b0;
    checks++;
    if (pass_1 !== 2'd0 || pass_2 !== 2'd0) begin
      failures++;
      $display("FAIL clear_beats_key got=%0d/%0d exp=0/0", pass_1, pass_2);
    end
    press(2'd3);
    checks++;
    if (pass_1 !== 2'd3 || pass_2 !== 2'd0) begin
      failures++;
      $display("FAIL clear_returns_wait_d1 got=%0d/%0d exp=3/0", pass_1, pass_2);
    end
    repeat (15) tick();
    press(2'd2);
    checks++;
    if (pass_2 !== 2'd2 || timeout_flag !== 1'b0) begin
      failures++;
      $display("FAIL key_beats_timeout got=%0d/%b exp=2/0", pass_2, timeout_flag);
    end
    tick();
    checks++;
    if (pass_ready !== 1'b1 || timeout_flag !== 1'b0 || pass_1 !== 2'd3) begin
      failures++;
      $display("FAIL ready_after_race got=%b/%b/%0d exp=1/0/3", pass_ready, timeout_flag, pass_1);
    end
  endtask

  task automatic test_reset_in_ready();
    rst_n = 1'b0;
    entry_sensor_raw = 1'b0;
    tick();
    checks++;
    if ({entry_detect, exit_detect, pass_1, pass_2, pass_ready, timeout_flag} !== 9'd0) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=%b",
               {entry_detect, exit_detect, pass_1, pass_2, pass_ready, timeout_flag}, 9'd0);
    end
    rst_n = 1'b1;
    press(2'd2);
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
    press(2'd1);
    tick();
    checks++;
    if (pass_1 !== 2'd0 || pass_2 !== 2'd0 || pass_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_keys_ignored got=%0d/%0d/%b exp=0/0/0", pass_1, pass_2, pass_ready);
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_password();
    test_timeout();
    test_clear_and_race();
    test_reset_in_ready();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
